edge_window_sequencer: RTL and testbench

//  Sequences one 9-engine 5x5 edge-detection core: gathers a 5x5 pixel window from a byte stream,

---
 rtl/edge_window_sequencer.sv | 120 ++++++++++++
 tb/tb_edge_window_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_window_sequencer.sv
// Window/result sequencer for a 9-engine 5x5 edge-detection core: gathers a 5x5 pixel
// window, starts the core, waits for ready, then drains the 3x3 sums as a byte stream.
//
// state | meaning
// LOAD  | accepting window pixels (o_pix_ready=1), pix_cnt = next byte slot
// START | window complete, one-cycle gradient start pulse to the core
// WAIT  | window frozen, waiting for core ready (ignored at wait_cnt==0) or timeout
// DRAIN | presenting captured sums one by one on the result handshake
module edge_window_sequencer #(
   parameter int PIX_W   = 8,
   parameter int WIN_N   = 25,
   parameter int RES_N   = 9,
   parameter int TMO_CYC = 64
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   i_pix_valid,
   input  logic [PIX_W-1:0]       i_pix_data,
   output logic                   o_pix_ready,
   output logic [WIN_N*PIX_W-1:0] o_window,
   output logic                   o_gradient_start,
   input  logic                   i_gradient_ready,
   input  logic [RES_N*PIX_W-1:0] i_sums,
   output logic                   o_res_valid,
   output logic [PIX_W-1:0]       o_res_data,
   output logic [3:0]             o_res_idx,
   input  logic                   i_res_ready,
   output logic                   o_busy,
   output logic                   o_tmo_err,
   input  logic                   i_err_clr
);

   localparam int WAIT_W = $clog2(TMO_CYC);

   typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

   state_t             state;
   logic [4:0]         pix_cnt;
   logic [3:0]         res_idx;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [PIX_W-1:0]   win_q [WIN_N];
   logic [PIX_W-1:0]   sum_q [RES_N];
   logic               tmo_err;
   logic               capture;
   logic               tmo_hit;

   // A ready seen on the first WAIT cycle may be left over from the previous window.
   assign capture = (state == WAIT) && (wait_cnt != '0) && i_gradient_ready;
   assign tmo_hit = (state == WAIT) && !capture && (wait_cnt == WAIT_W'(TMO_CYC-1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= LOAD;
         pix_cnt  <= '0;
         res_idx  <= '0;
         wait_cnt <= '0;
         tmo_err  <= 1'b0;
         for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
         for (int i = 0; i < RES_N; i++) sum_q[i] <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (i_pix_valid) begin
                  win_q[pix_cnt] <= i_pix_data;
                  if (pix_cnt == 5'(WIN_N-1)) begin
                     pix_cnt <= '0;
                     state   <= START;
                  end else begin
                     pix_cnt <= pix_cnt + 5'd1;
                  end
               end
            end
            START: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (capture) begin
                  for (int i = 0; i < RES_N; i++) sum_q[i] <= i_sums[i*PIX_W +: PIX_W];
                  res_idx <= '0;
                  state   <= DRAIN;
               end else if (tmo_hit) begin
                  state <= LOAD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (i_res_ready) begin
                  if (res_idx == 4'(RES_N-1)) begin
                     res_idx <= '0;
                     state   <= LOAD;
                  end else begin
                     res_idx <= res_idx + 4'd1;
                  end
               end
            end
            default: state <= LOAD;
         endcase

         if (tmo_hit)
            tmo_err <= 1'b1;
         else if (i_err_clr)
            tmo_err <= 1'b0;
      end
   end

   for (genvar g = 0; g < WIN_N; g++) begin : g_win
      assign o_window[g*PIX_W +: PIX_W] = win_q[g];
   end

   assign o_pix_ready      = (state == LOAD);
   assign o_gradient_start = (state == START);
   assign o_res_valid      = (state == DRAIN);
   assign o_res_data       = sum_q[res_idx];
   assign o_res_idx        = res_idx;
   assign o_busy           = !((state == LOAD) && (pix_cnt == 5'd0));
   assign o_tmo_err        = tmo_err;

endmodule

// File: tb/tb_edge_window_sequencer.sv
// Directed bench for edge_window_sequencer: a core model answers start pulses, a monitor
// pops expected {idx,data} results from a scoreboard queue on every result beat.
module tb_edge_window_sequencer;
   localparam int PIX_W = 8, WIN_N = 25, RES_N = 9, TMO_CYC = 64;

   logic                   clk = 1'b0;
   logic                   n_rst = 1'b0;
   logic                   i_pix_valid = 1'b0;
   logic [PIX_W-1:0]       i_pix_data = '0;
   logic                   o_pix_ready;
   logic [WIN_N*PIX_W-1:0] o_window;
   logic                   o_gradient_start;
   logic                   i_gradient_ready = 1'b0;
   logic [RES_N*PIX_W-1:0] i_sums = '0;
   logic                   o_res_valid;
   logic [PIX_W-1:0]       o_res_data;
   logic [3:0]             o_res_idx;
   logic                   i_res_ready = 1'b1;
   logic                   o_busy;
   logic                   o_tmo_err;
   logic                   i_err_clr = 1'b0;

   edge_window_sequencer #(.PIX_W(PIX_W), .WIN_N(WIN_N), .RES_N(RES_N), .TMO_CYC(TMO_CYC)) dut (
      .clk(clk), .n_rst(n_rst),
      .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
      .o_window(o_window), .o_gradient_start(o_gradient_start),
      .i_gradient_ready(i_gradient_ready), .i_sums(i_sums),
      .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_idx(o_res_idx),
      .i_res_ready(i_res_ready), .o_busy(o_busy), .o_tmo_err(o_tmo_err), .i_err_clr(i_err_clr)
   );

   always #5 clk = ~clk;

   int vecs = 0, errs = 0, cyc = 0;
   logic [11:0] sb [$];
   int core_mode = 0;   // 0: ready 3 cycles after start, 1: ready held high, 2: never ready
   int core_cd = 0;
   int rr_mode = 0, rr_k = 0;
   int start_cnt = 0, start_cyc = 0, exp_lat = 4;
   logic prev_valid = 1'b0, hold_pend = 1'b0;
   logic [11:0] hold_val = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Core model: drops ready on start (unless holding), raises it 3 cycles later.
   always @(negedge clk) begin
      if (!n_rst) begin
         i_gradient_ready = 1'b0;
         core_cd = 0;
      end else if (o_gradient_start) begin
         if (core_mode != 1) i_gradient_ready = 1'b0;
         core_cd = 3;
      end else if (core_cd > 0) begin
         core_cd--;
         if (core_cd == 0 && core_mode == 0) i_gradient_ready = 1'b1;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rr_mode == 0) begin
         i_res_ready = 1'b1;
      end else begin
         case (rr_k)
            0, 3:    i_res_ready = 1'b1;
            default: i_res_ready = 1'b0;
         endcase
         rr_k = (rr_k + 1) % 4;
      end
   end

   always @(negedge clk) begin
      logic [11:0] e;
      if (!n_rst) begin
         prev_valid = 1'b0;
         hold_pend  = 1'b0;
      end else begin
         if (o_gradient_start) begin
            start_cnt++;
            start_cyc = cyc;
         end
         if (hold_pend)
            chk("res_stable", {o_res_valid, o_res_idx, o_res_data}, {1'b1, hold_val});
         if (o_res_valid && !prev_valid)
            chk("first_res_latency", 256'(cyc - start_cyc), 256'(exp_lat));
         if (o_res_valid && i_res_ready) begin
            if (sb.size() == 0) begin
               chk("res_unexpected", o_res_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("res_beat", {o_res_idx, o_res_data}, e);
            end
         end
         hold_pend  = o_res_valid && !i_res_ready;
         hold_val   = {o_res_idx, o_res_data};
         prev_valid = o_res_valid;
      end
   end

   task automatic push_pixel(input logic [7:0] d);
      int t = 0;
      i_pix_valid = 1'b1;
      i_pix_data  = d;
      @(negedge clk);
      while (!o_pix_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("pix_ready_wait", o_pix_ready, 1'b1);
      @(posedge clk);
      #1;
      i_pix_valid = 1'b0;
   endtask

   // Loads one window; leaves the caller in the START cycle (1 time unit after the edge).
   task automatic load_window(input logic [7:0] pbase, input logic [7:0] sbase,
                              input bit gap, input bit push_exp);
      logic [WIN_N*PIX_W-1:0] ew;
      int s0;
      for (int k = 0; k < RES_N; k++) begin
         i_sums[k*PIX_W +: PIX_W] = 8'(sbase + k);
         if (push_exp) sb.push_back({4'(k), 8'(sbase + k)});
      end
      for (int i = 0; i < WIN_N; i++) ew[i*PIX_W +: PIX_W] = 8'(pbase + i);
      s0 = start_cnt;
      for (int i = 0; i < WIN_N; i++) begin
         if (i == WIN_N - 1) begin
            chk("busy_mid_load", o_busy, 1'b1);
            chk("no_early_start", 256'(start_cnt), 256'(s0));
         end
         push_pixel(8'(pbase + i));
         if (gap && i != WIN_N - 1) begin
            @(posedge clk);
            #1;
         end
      end
      chk("start_pulse", o_gradient_start, 1'b1);
      chk("pix_ready_in_start", o_pix_ready, 1'b0);
      chk("window_bytes", o_window, ew);
   endtask

   task automatic wait_drain(input int s0);
      bit done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         if (sb.size() == 0 && !o_res_valid) done = 1'b1;
      end
      chk("drain_done", done, 1'b1);
      chk("one_start_per_window", 256'(start_cnt - s0), 256'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      bit found;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pix_ready", o_pix_ready, 1'b1);
      chk("rst_outputs", {o_gradient_start, o_res_valid, o_res_data, o_res_idx, o_busy, o_tmo_err},
          '0);
      chk("rst_window", o_window, '0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // T1: back-to-back pixels, ready 3 cycles after start
      s0 = start_cnt; exp_lat = 4;
      load_window(8'd1, 8'h10, 1'b0, 1'b1);
      wait_drain(s0);

      // T2: downstream stalls with 1-0-0-1 ready pattern
      rr_mode = 1; rr_k = 0;
      s0 = start_cnt;
      load_window(8'd30, 8'h20, 1'b0, 1'b1);
      wait_drain(s0);
      rr_mode = 0;

      // T3: pixel valid every other cycle
      s0 = start_cnt;
      load_window(8'd1, 8'h30, 1'b1, 1'b1);
      wait_drain(s0);

      // T4: ready stays high from the previous window -> capture at wait_cnt==1
      core_mode = 1; exp_lat = 3;
      s0 = start_cnt;
      load_window(8'd60, 8'h40, 1'b0, 1'b1);
      wait_drain(s0);
      core_mode = 0; exp_lat = 4;

      // T5: ready never arrives -> timeout after TMO_CYC WAIT cycles
      core_mode = 2;
      load_window(8'd90, 8'h50, 1'b0, 1'b0);
      repeat (TMO_CYC) @(posedge clk);
      #1;
      chk("tmo_not_yet", {o_tmo_err, o_busy, o_pix_ready}, 3'b010);
      @(posedge clk);
      #1;
      chk("tmo_set_back_to_load", {o_tmo_err, o_busy, o_pix_ready}, 3'b101);
      @(posedge clk);
      #1;
      chk("tmo_sticky", o_tmo_err, 1'b1);
      i_err_clr = 1'b1;
      @(posedge clk);
      #1;
      i_err_clr = 1'b0;
      chk("tmo_cleared", o_tmo_err, 1'b0);
      chk("tmo_no_results", 256'(sb.size()), 256'd0);
      core_mode = 0;

      // T6: reset in DRAIN at res_idx 4
      load_window(8'd120, 8'h60, 1'b0, 1'b1);
      found = 1'b0;
      for (int t = 0; t < 100 && !found; t++) begin
         @(negedge clk);
         if (o_res_valid && o_res_idx == 4'd4) found = 1'b1;
      end
      chk("reach_idx4", found, 1'b1);
      #1;
      n_rst = 1'b0;
      #1;
      chk("midrst_outputs", {o_gradient_start, o_res_valid, o_res_data, o_res_idx, o_busy, o_tmo_err},
          '0);
      chk("midrst_pix_ready", o_pix_ready, 1'b1);
      chk("midrst_window", o_window, '0);
      sb.delete();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // Clean window after the reset
      s0 = start_cnt;
      load_window(8'd200, 8'h70, 1'b0, 1'b1);
      wait_drain(s0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
